ast_tensor_job_sequencer: RTL and testbench

Command-driven sequencer that sits directly in front of and behind `ast_tensor_system_sv`. It accepts one matrix-multiply job (X = A·B) at a time and reads A and B from a word-addressed source memory. It streams them into the tensor system's FIFO load port, pulses `start`, waits for `done`, pops every result word through `ren`, and writes the results row-major to a destination memory. It replaces host-side software sequencing of the `wen`/`set`/`depth`/`width`/`start`/`ren` protocol.

---
 rtl/ast_tensor_job_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_ast_tensor_job_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ast_tensor_job_sequencer.sv
// Single-job sequencer that loads A/B into ast_tensor_system_sv, starts it and drains X to memory.
// Define AST_SEQ_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT_CYCLES).
module ast_tensor_job_sequencer #(
    parameter int DATAWIDTH      = 14,
    parameter int SIZE           = 4,
    parameter int ADDRWIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [$clog2(SIZE):0]     cmd_q,
    input  logic [$clog2(SIZE):0]     cmd_r,
    input  logic [$clog2(SIZE):0]     cmd_k,
    input  logic [ADDRWIDTH-1:0]      cmd_a_base,
    input  logic [ADDRWIDTH-1:0]      cmd_b_base,
    input  logic [ADDRWIDTH-1:0]      cmd_x_base,
    input  logic                      cmd_relu,
    output logic                      rd_en,
    output logic [ADDRWIDTH-1:0]      rd_addr,
    input  logic [DATAWIDTH-1:0]      rd_data,
    output logic                      wr_en,
    output logic [ADDRWIDTH-1:0]      wr_addr,
    output logic [DATAWIDTH-1:0]      wr_data,
    output logic [$clog2(SIZE):0]     ts_depth,
    output logic [$clog2(SIZE):0]     ts_width,
    output logic [DATAWIDTH-1:0]      ts_data,
    output logic                      ts_wen,
    output logic                      ts_set,
    output logic                      ts_relu,
    output logic                      ts_start,
    output logic                      ts_ren,
    input  logic                      ts_busy,
    input  logic                      ts_done,
    input  logic [DATAWIDTH-1:0]      ts_data_out,
    output logic                      job_done,
    output logic                      job_error
);

    localparam int DW = $clog2(SIZE) + 1;
    localparam int CW = $clog2(SIZE * SIZE) + 1;
    localparam logic [DW-1:0] SIZE_D = DW'(SIZE);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, START, WAIT, DRAIN, FINISH} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        tot_a;
    logic [CW-1:0]        tot_b;
    logic [CW-1:0]        tot_x;
    logic [DW-1:0]        r_l;
    logic [DW-1:0]        k_l;
    logic [ADDRWIDTH-1:0] b_base_l;
    logic [ADDRWIDTH-1:0] x_base_l;
    logic                 cmd_bad;
`ifdef AST_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0]        wdog;
`endif

    assign cmd_bad = (cmd_q == '0) || (cmd_q > SIZE_D) ||
                     (cmd_r == '0) || (cmd_r > SIZE_D) ||
                     (cmd_k == '0) || (cmd_k > SIZE_D);

    assign cmd_ready = (state == IDLE) && !ts_busy;

    // Memory and tensor read data are one cycle behind their strobes, so they pass straight through.
    assign ts_data = ts_wen ? rd_data : '0;
    assign wr_data = wr_en ? ts_data_out : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            ts_depth  <= '0;
            ts_width  <= '0;
            ts_wen    <= 1'b0;
            ts_set    <= 1'b0;
            ts_relu   <= 1'b0;
            ts_start  <= 1'b0;
            ts_ren    <= 1'b0;
            job_done  <= 1'b0;
            job_error <= 1'b0;
            cnt       <= '0;
            tot_a     <= '0;
            tot_b     <= '0;
            tot_x     <= '0;
            r_l       <= '0;
            k_l       <= '0;
            b_base_l  <= '0;
            x_base_l  <= '0;
`ifdef AST_SEQ_TIMEOUT_EN
            wdog      <= '0;
`endif
        end else begin
            job_done  <= 1'b0;
            job_error <= 1'b0;
            ts_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_bad) begin
                            job_error <= 1'b1;
                        end else begin
                            state    <= LOAD_A;
                            r_l      <= cmd_r;
                            k_l      <= cmd_k;
                            b_base_l <= cmd_b_base;
                            x_base_l <= cmd_x_base;
                            tot_a    <= CW'(cmd_q) * CW'(cmd_r);
                            tot_b    <= CW'(cmd_r) * CW'(cmd_k);
                            tot_x    <= CW'(cmd_q) * CW'(cmd_k);
                            ts_relu  <= cmd_relu;
                            ts_set   <= 1'b0;
                            ts_depth <= cmd_r;
                            ts_width <= cmd_q;
                            rd_en    <= 1'b1;
                            rd_addr  <= cmd_a_base;
                            cnt      <= CW'(1);
                        end
                    end
                end
                LOAD_A, LOAD_B: begin
                    ts_wen <= rd_en;
                    // The cycle after the last read carries only the trailing FIFO write.
                    if (rd_en) begin
                        if (cnt == ((state == LOAD_A) ? tot_a : tot_b)) begin
                            rd_en <= 1'b0;
                        end else begin
                            rd_addr <= rd_addr + ADDRWIDTH'(1);
                            cnt     <= cnt + CW'(1);
                        end
                    end else if (state == LOAD_A) begin
                        state    <= LOAD_B;
                        ts_set   <= 1'b1;
                        ts_depth <= k_l;
                        ts_width <= r_l;
                        rd_en    <= 1'b1;
                        rd_addr  <= b_base_l;
                        cnt      <= CW'(1);
                    end else begin
                        state    <= START;
                        ts_start <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef AST_SEQ_TIMEOUT_EN
                    wdog  <= '0;
`endif
                end
                WAIT: begin
                    if (ts_done) begin
                        state   <= DRAIN;
                        ts_ren  <= 1'b1;
                        cnt     <= CW'(1);
                        wr_addr <= x_base_l;
                    end
`ifdef AST_SEQ_TIMEOUT_EN
                    else if (wdog == WW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= IDLE;
                        job_error <= 1'b1;
                        ts_relu   <= 1'b0;
                        ts_set    <= 1'b0;
                        ts_depth  <= '0;
                        ts_width  <= '0;
                        rd_addr   <= '0;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
`endif
                end
                DRAIN: begin
                    wr_en <= ts_ren;
                    if (wr_en) begin
                        wr_addr <= wr_addr + ADDRWIDTH'(1);
                    end
                    if (ts_ren) begin
                        if (cnt == tot_x) begin
                            ts_ren <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        state    <= FINISH;
                        job_done <= 1'b1;
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    ts_relu  <= 1'b0;
                    ts_set   <= 1'b0;
                    ts_depth <= '0;
                    ts_width <= '0;
                    rd_addr  <= '0;
                    wr_addr  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ast_tensor_job_sequencer.sv
// Directed bench: source/destination memories and a behavioural tensor system around the sequencer.
module tb_ast_tensor_job_sequencer;

    localparam int DWD = 14;
    localparam int SZ  = 4;
    localparam int AW  = 8;
    localparam int TO  = 256;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [2:0]     cmd_q = '0, cmd_r = '0, cmd_k = '0;
    logic [AW-1:0]  cmd_a_base = '0, cmd_b_base = '0, cmd_x_base = '0;
    logic           cmd_relu = 1'b0;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [DWD-1:0] rd_data = '0;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DWD-1:0] wr_data;
    logic [2:0]     ts_depth, ts_width;
    logic [DWD-1:0] ts_data;
    logic           ts_wen, ts_set, ts_relu, ts_start, ts_ren;
    logic           ts_busy;
    logic           ts_done = 1'b0;
    logic [DWD-1:0] ts_data_out = '0;
    logic           job_done, job_error;

    logic busy_force = 1'b0;
    logic m_busy = 1'b0;
    logic no_done = 1'b0;
    int   done_delay = 0;

    assign ts_busy = m_busy | busy_force;

    always #5 clk = ~clk;

    ast_tensor_job_sequencer #(.DATAWIDTH(DWD), .SIZE(SZ), .ADDRWIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_q(cmd_q), .cmd_r(cmd_r), .cmd_k(cmd_k),
        .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base), .cmd_x_base(cmd_x_base),
        .cmd_relu(cmd_relu), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ts_depth(ts_depth), .ts_width(ts_width), .ts_data(ts_data),
        .ts_wen(ts_wen), .ts_set(ts_set), .ts_relu(ts_relu), .ts_start(ts_start), .ts_ren(ts_ren),
        .ts_busy(ts_busy), .ts_done(ts_done), .ts_data_out(ts_data_out),
        .job_done(job_done), .job_error(job_error)
    );

    // Source memory: one-cycle read latency.
    logic [DWD-1:0] src [256];
    always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];

    // Behavioural tensor system: collects A and B streams, multiplies on start, pops X on ren.
    logic [DWD-1:0] a_mem [16];
    logic [DWD-1:0] b_mem [16];
    logic [DWD-1:0] x_mem [16];
    int a_n = 0, b_n = 0, x_ptr = 0, dcnt = 0;
    int m_q = 0, m_r = 0, m_k = 0, m_rb = 0;

    function automatic logic [DWD-1:0] xval(input int n, input logic relu);
        int acc, i, l;
        logic [31:0] res;
        if (m_k == 0 || n >= m_q * m_k) return '0;
        i = n / m_k;
        l = n % m_k;
        acc = 0;
        for (int j = 0; j < m_r; j++)
            acc = acc + int'($signed(a_mem[i*m_r+j])) * int'($signed(b_mem[j*m_k+l]));
        if (relu && acc < 0) acc = 0;
        res = acc;
        return res[DWD-1:0];
    endfunction

    always @(posedge clk) begin
        ts_done <= 1'b0;
        if (reset) begin
            a_n <= 0; b_n <= 0; x_ptr <= 0; m_busy <= 1'b0;
        end else begin
            if (ts_wen && !ts_set) begin
                a_mem[a_n] <= ts_data; a_n <= a_n + 1; m_q <= int'(ts_width); m_r <= int'(ts_depth);
            end
            if (ts_wen && ts_set) begin
                b_mem[b_n] <= ts_data; b_n <= b_n + 1; m_k <= int'(ts_depth); m_rb <= int'(ts_width);
            end
            if (ts_start) begin
                for (int n = 0; n < 16; n++) x_mem[n] <= xval(n, ts_relu);
                a_n <= 0; b_n <= 0; x_ptr <= 0;
                if (no_done) m_busy <= 1'b1;
                else if (done_delay == 0) ts_done <= 1'b1;
                else begin m_busy <= 1'b1; dcnt <= done_delay - 1; end
            end else if (m_busy && !no_done) begin
                if (dcnt == 0) begin ts_done <= 1'b1; m_busy <= 1'b0; end
                else dcnt <= dcnt - 1;
            end
            if (ts_ren) begin ts_data_out <= x_mem[x_ptr]; x_ptr <= x_ptr + 1; end
        end
    end

    // Observation at negedge: event cycles, strobe counts and destination memory.
    logic [DWD-1:0] dst [256];
    int cyc = 0, acc_cyc = 0, last_a_wen = 0, last_b_wen = 0, b_rd_first = 0;
    int start_cyc = 0, done_cyc = 0, first_ren = 0, jd_cyc = 0, je_cyc = 0;
    int rd_cnt = 0, wr_cnt = 0, jd_cnt = 0, je_cnt = 0, relu_cnt = 0;
    logic prev_brd = 1'b0, prev_ren = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_brd <= rd_en && ts_set;
        prev_ren <= ts_ren;
        if (cmd_valid && cmd_ready) acc_cyc <= cyc;
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (rd_en && ts_set && !prev_brd) b_rd_first <= cyc;
        if (ts_wen && !ts_set) last_a_wen <= cyc;
        if (ts_wen && ts_set) last_b_wen <= cyc;
        if (ts_start) start_cyc <= cyc;
        if (ts_done) done_cyc <= cyc;
        if (ts_ren && !prev_ren) first_ren <= cyc;
        if (ts_relu) relu_cnt <= relu_cnt + 1;
        if (wr_en) begin dst[wr_addr] <= wr_data; wr_cnt <= wr_cnt + 1; end
        if (job_done) begin jd_cyc <= cyc; jd_cnt <= jd_cnt + 1; end
        if (job_error) begin je_cyc <= cyc; je_cnt <= je_cnt + 1; end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input int q, input int r, input int k, input int a, input int b,
                          input int x, input logic relu);
        @(posedge clk); #1;
        cmd_q = 3'(q); cmd_r = 3'(r); cmd_k = 3'(k);
        cmd_a_base = AW'(a); cmd_b_base = AW'(b); cmd_x_base = AW'(x);
        cmd_relu = relu; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (job_done || job_error) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk(tag, 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    int rd0, wr0, jd0, je0, rl0;

    task automatic snap();
        rd0 = rd_cnt; wr0 = wr_cnt; jd0 = jd_cnt; je0 = je_cnt; rl0 = relu_cnt;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", 32'({rd_en, wr_en, ts_wen, ts_set, ts_start, ts_ren, ts_relu, job_done, job_error}), 32'd0);
        chk("rst_buses", 32'({rd_addr, wr_addr, ts_depth, ts_width, ts_data, wr_data}), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        busy_force = 1'b1;
        @(negedge clk);
        chk("ready_busy", 32'(cmd_ready), 32'd0);
        busy_force = 1'b0;
        @(negedge clk);
        chk("ready_idle", 32'(cmd_ready), 32'd1);

        // Job 1: 2x2 times identity.
        src[8'h00] = 14'd1; src[8'h01] = 14'd2; src[8'h02] = 14'd3; src[8'h03] = 14'd4;
        src[8'h10] = 14'd1; src[8'h11] = 14'd0; src[8'h12] = 14'd0; src[8'h13] = 14'd1;
        done_delay = 3;
        snap();
        launch(2, 2, 2, 'h00, 'h10, 'h40, 1'b0);
        wait_end("j1_end", 200);
        for (int n = 0; n < 4; n++) chk("j1_x", 32'(dst[8'h40 + n]), 32'(n + 1));
        chk("j1_wr_cnt", 32'(wr_cnt - wr0), 32'd4);
        chk("j1_rd_cnt", 32'(rd_cnt - rd0), 32'd8);
        chk("j1_done_cnt", 32'(jd_cnt - jd0), 32'd1);
        chk("j1_last_a_wen", 32'(last_a_wen - acc_cyc), 32'd5);
        chk("j1_first_b_rd", 32'(b_rd_first - acc_cyc), 32'd6);
        chk("j1_last_b_wen", 32'(last_b_wen - acc_cyc), 32'd10);
        chk("j1_start", 32'(start_cyc - acc_cyc), 32'd11);
        chk("j1_done_lat", 32'(done_cyc - start_cyc), 32'd4);
        chk("j1_first_ren", 32'(first_ren - done_cyc), 32'd1);
        chk("j1_job_done", 32'(jd_cyc - done_cyc), 32'd6);

        // Job 2: 4x4 all-ones, done in the WAIT entry cycle.
        for (int i = 0; i < 16; i++) begin src[8'h20 + i] = 14'd1; src[8'h30 + i] = 14'd1; end
        done_delay = 0;
        snap();
        launch(4, 4, 4, 'h20, 'h30, 'h80, 1'b0);
        wait_end("j2_end", 300);
        for (int n = 0; n < 16; n++) chk("j2_x", 32'(dst[8'h80 + n]), 32'd4);
        chk("j2_wr_cnt", 32'(wr_cnt - wr0), 32'd16);
        chk("j2_rd_cnt", 32'(rd_cnt - rd0), 32'd32);
        chk("j2_load_a_len", 32'(last_a_wen - acc_cyc), 32'd17);
        chk("j2_load_b_len", 32'(last_b_wen - last_a_wen), 32'd17);
        chk("j2_wait_1cyc", 32'(done_cyc - start_cyc), 32'd1);
        chk("j2_first_ren", 32'(first_ren - done_cyc), 32'd1);
        chk("j2_job_done", 32'(jd_cyc - done_cyc), 32'd18);

        // Job 3: 1x3 by 3x2, A and X addresses wrap past 0xFF.
        src[8'hFE] = 14'd1; src[8'hFF] = 14'd2; src[8'h00] = 14'd3;
        src[8'h58] = 14'd1; src[8'h59] = 14'd0; src[8'h5A] = 14'd0;
        src[8'h5B] = 14'd1; src[8'h5C] = 14'd1; src[8'h5D] = 14'd1;
        done_delay = 2;
        snap();
        launch(1, 3, 2, 'hFE, 'h58, 'hFF, 1'b0);
        wait_end("j3_end", 200);
        chk("j3_x0", 32'(dst[8'hFF]), 32'd4);
        chk("j3_x1", 32'(dst[8'h00]), 32'd5);
        chk("j3_wr_cnt", 32'(wr_cnt - wr0), 32'd2);
        chk("j3_a_depth", 32'(m_r), 32'd3);
        chk("j3_a_width", 32'(m_q), 32'd1);
        chk("j3_b_depth", 32'(m_k), 32'd2);
        chk("j3_b_width", 32'(m_rb), 32'd3);

        // Jobs 4/5: (-2)*3 without then with ReLU, same destination.
        src[8'h70] = 14'h3FFE; src[8'h71] = 14'd3;
        done_delay = 0;
        snap();
        launch(1, 1, 1, 'h70, 'h71, 'h90, 1'b0);
        wait_end("j4_end", 200);
        chk("j4_neg", 32'(dst[8'h90]), 32'h3FFA);
        chk("j4_relu_cnt", 32'(relu_cnt - rl0), 32'd0);
        snap();
        launch(1, 1, 1, 'h70, 'h71, 'h90, 1'b1);
        wait_end("j5_end", 200);
        chk("j5_relu", 32'(dst[8'h90]), 32'd0);
        chk("j5_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
        chk("j5_relu_cnt", 32'(relu_cnt - rl0), 32'd9);
        chk("j5_job_len", 32'(jd_cyc - acc_cyc), 32'd9);

        // Rejected commands: K=0 and Q>SIZE.
        snap();
        launch(2, 2, 0, 'h00, 'h10, 'h40, 1'b0);
        wait_end("e1_end", 20);
        chk("e1_err_cnt", 32'(je_cnt - je0), 32'd1);
        chk("e1_err_cyc", 32'(je_cyc - acc_cyc), 32'd1);
        chk("e1_no_rd", 32'(rd_cnt - rd0), 32'd0);
        chk("e1_ready", 32'(cmd_ready), 32'd1);
        launch(5, 1, 1, 'h00, 'h10, 'h40, 1'b0);
        wait_end("e2_end", 20);
        chk("e2_err_cnt", 32'(je_cnt - je0), 32'd2);
        chk("e2_no_rd", 32'(rd_cnt - rd0), 32'd0);
        chk("e2_no_done", 32'(jd_cnt - jd0), 32'd0);

        // Reset in the middle of LOAD_B.
        launch(4, 4, 4, 'h20, 'h30, 'hA0, 1'b0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (rd_en && ts_set) begin seen = 1'b1; break; end
            end
            chk("mr_reach_load_b", 32'(seen), 32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mr_strobes", 32'({rd_en, wr_en, ts_wen, ts_set, ts_start, ts_ren, ts_relu, job_done, job_error}), 32'd0);
        chk("mr_buses", 32'({rd_addr, wr_addr, ts_depth, ts_width, ts_data, wr_data}), 32'd0);
        chk("mr_ready", 32'(cmd_ready), 32'd1);
        snap();
        @(posedge clk); #1 reset = 1'b0;
        repeat (60) @(negedge clk);
        chk("mr_no_rd", 32'(rd_cnt - rd0), 32'd0);
        chk("mr_no_wr", 32'(wr_cnt - wr0), 32'd0);
        chk("mr_no_done", 32'(jd_cnt - jd0), 32'd0);

`ifdef AST_SEQ_TIMEOUT_EN
        no_done = 1'b1;
        snap();
        launch(1, 1, 1, 'h70, 'h71, 'hB0, 1'b0);
        wait_end("to_end", 600);
        chk("to_err_cnt", 32'(je_cnt - je0), 32'd1);
        chk("to_err_cyc", 32'(je_cyc - (start_cyc + 1)), 32'(TO));
        chk("to_no_wr", 32'(wr_cnt - wr0), 32'd0);
        chk("to_no_done", 32'(jd_cnt - jd0), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed hang expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
